// File: rtl/score_keeper.sv
// Score keeper: saturating game score, high score and a background
// double-dabble converter that publishes the score as five BCD digits.
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   rst_n        - synchronous active-low reset
//   apple_eaten  - one-cycle pulse, add POINTS_PER_APPLE to the score
//   game_restart - one-cycle pulse, clear the score (wins over apple)
//   score        - current binary score, registered
//   high_score   - highest score since reset, registered
//   digits       - packed BCD of score, [19:16] ten-thousands .. [3:0] units
//   digits_valid - one-cycle pulse whenever digits is updated
//   busy         - high while a conversion is loading or shifting
module score_keeper #(
    parameter logic [15:0] POINTS_PER_APPLE = 16'd1,
    parameter logic [15:0] SCORE_MAX        = 16'd65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apple_eaten,
    input  logic        game_restart,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [19:0] digits,
    output logic        digits_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        pending;
    logic [15:0] src;
    logic [19:0] bcd;
    logic [3:0]  cnt;

    logic        wr;
    logic [16:0] sum;
    logic [15:0] score_nx;
    logic [19:0] bcd_adj;
    logic [35:0] shifted;

    // Sum is one bit wider so that the saturation compare never sees a wrap.
    assign sum = {1'b0, score} + {1'b0, POINTS_PER_APPLE};
    assign wr  = apple_eaten | game_restart;

    always_comb begin
        score_nx = score;
        if (game_restart) begin
            score_nx = 16'd0;
        end else if (apple_eaten) begin
            if (sum > {1'b0, SCORE_MAX}) begin
                score_nx = SCORE_MAX;
            end else begin
                score_nx = sum[15:0];
            end
        end
    end

    // Double-dabble correction: any digit of 5 or more becomes >= 8 so the
    // following shift carries into the next decimal place.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, src} << 1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (pending) state_nx = LOAD;
            LOAD:  state_nx = SHIFT;
            SHIFT: if (cnt == 4'd15) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == LOAD) || (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score        <= 16'd0;
            high_score   <= 16'd0;
            digits       <= 20'h00000;
            digits_valid <= 1'b0;
            pending      <= 1'b0;
            src          <= 16'd0;
            bcd          <= 20'h00000;
            cnt          <= 4'd0;
        end else begin
            digits_valid <= 1'b0;

            if (wr) begin
                score <= score_nx;
                if (score_nx > high_score) begin
                    high_score <= score_nx;
                end
            end

            // A write on the LOAD edge is newer than the captured value,
            // so it keeps pending set for a follow-up conversion.
            if (state == LOAD) begin
                pending <= wr;
            end else if (wr) begin
                pending <= 1'b1;
            end

            unique case (state)
                LOAD: begin
                    src <= score;
                    bcd <= 20'h00000;
                    cnt <= 4'd0;
                end
                SHIFT: begin
                    bcd <= shifted[35:16];
                    src <= shifted[15:0];
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
                    digits       <= bcd;
                    digits_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper with a digits scoreboard.
// Expected conversions are queued at stimulus time and popped on digits_valid.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        apple_eaten = 1'b0;
    logic        game_restart = 1'b0;
    logic [15:0] score;
    logic [15:0] high_score;
    logic [19:0] digits;
    logic        digits_valid;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit sb_en = 1'b0;

    typedef struct {
        logic [19:0] d;
        int          due;
    } exp_t;

    exp_t sbq[$];

    score_keeper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apple_eaten  (apple_eaten),
        .game_restart (game_restart),
        .score        (score),
        .high_score   (high_score),
        .digits       (digits),
        .digits_valid (digits_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_en && digits_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'(digits_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_digits", 32'(digits), 32'(e.d));
                chk("sb_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input logic a, input logic r);
        apple_eaten  = a;
        game_restart = r;
        tick(1);
        apple_eaten  = 1'b0;
        game_restart = 1'b0;
    endtask

    task automatic push(input logic [19:0] d, input int due);
        exp_t e;
        e.d   = d;
        e.due = due;
        sbq.push_back(e);
    endtask

    task automatic bulk(input int n);
        sb_en       = 1'b0;
        apple_eaten = 1'b1;
        tick(n);
        apple_eaten = 1'b0;
        tick(60);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < limit) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(sbq.size()), 32'd0);
        tick(1);
    endtask

    int e0;

    initial begin
        // reset state
        rst_n = 1'b0;
        tick(3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_high", 32'(high_score), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_valid", 32'(digits_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        sb_en = 1'b1;
        tick(2);

        // single apple, 19-edge latency
        push(20'h00001, cyc + 20);
        step(1'b1, 1'b0);
        chk("one_score", 32'(score), 32'd1);
        chk("one_high", 32'(high_score), 32'd1);
        chk("one_busy_idle", 32'(busy), 32'd0);
        tick(2);
        chk("one_busy_load", 32'(busy), 32'd1);
        wait_drain("one_drain", 40);

        // preload 12345, then restart keeps high score
        bulk(12344);
        chk("pre_score", 32'(score), 32'd12345);
        chk("pre_digits", 32'(digits), 32'h12345);
        sb_en = 1'b1;
        push(20'h00000, cyc + 20);
        step(1'b0, 1'b1);
        chk("rs_score", 32'(score), 32'd0);
        chk("rs_high", 32'(high_score), 32'd12345);
        wait_drain("rs_drain", 40);

        // saturation at 65535
        bulk(65540);
        chk("sat_score", 32'(score), 32'd65535);
        chk("sat_high", 32'(high_score), 32'd65535);
        chk("sat_digits", 32'(digits), 32'h65535);
        chk("sat_busy", 32'(busy), 32'd0);

        // coalescing: three writes, two conversions
        sb_en = 1'b0;
        step(1'b0, 1'b1);
        bulk(7);
        sb_en = 1'b1;
        chk("co_start", 32'(score), 32'd7);
        e0 = cyc + 1;
        push(20'h00008, e0 + 19);
        push(20'h00010, e0 + 38);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("co_score", 32'(score), 32'd10);
        wait_drain("co_drain", 80);
        chk("co_digits", 32'(digits), 32'h00010);

        // apple and restart together
        sb_en = 1'b0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bulk(40);
        sb_en = 1'b1;
        chk("both_pre_high", 32'(high_score), 32'd40);
        push(20'h00000, cyc + 20);
        step(1'b1, 1'b1);
        chk("both_score", 32'(score), 32'd0);
        chk("both_high", 32'(high_score), 32'd40);
        wait_drain("both_drain", 40);

        // reset aborts a conversion of 999
        bulk(998);
        sb_en = 1'b1;
        step(1'b1, 1'b0);
        tick(6);
        chk("ab_score", 32'(score), 32'd999);
        chk("ab_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("ab_score0", 32'(score), 32'd0);
        chk("ab_high0", 32'(high_score), 32'd0);
        chk("ab_digits0", 32'(digits), 32'd0);
        chk("ab_valid0", 32'(digits_valid), 32'd0);
        chk("ab_busy0", 32'(busy), 32'd0);
        tick(40);
        chk("ab_digits_hold", 32'(digits), 32'd0);
        chk("ab_queue", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter POINTS_PER_APPLE, default 1, 16-bit score increment per apple_eaten pulse.
REQ-002 Parameter SCORE_MAX, default 16'd65535, saturation ceiling for score.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 apple_eaten  input  1  one-cycle pulse; snake head consumed an apple.
REQ-006 game_restart  input  1  one-cycle pulse; new game starts, score clears.
REQ-007 score  output  16  current binary score, registered.
REQ-008 high_score  output  16  highest score since reset, registered.
REQ-009 digits  output  20  five packed BCD digits of score; [19:16] ten-thousands ... [3:0] units; registered.
REQ-010 digits_valid  output  1  one-cycle pulse on each digits update.
REQ-011 busy  output  1  high while a BCD conversion is in progress (LOAD or SHIFT state).

Function
REQ-012 The block SHALL use only clk; no other clock, no combinational path from any input to any output.
REQ-013 On an edge with apple_eaten=1 and game_restart=0, score SHALL become min(score + POINTS_PER_APPLE, SCORE_MAX), computed 17-bit wide, no wrap.
REQ-014 On an edge with game_restart=1, score SHALL become 0, regardless of apple_eaten (restart has priority).
REQ-015 On the same edge score is written with value V, high_score SHALL become V if V > high_score, else hold; game_restart SHALL NOT clear high_score.
REQ-016 Any edge writing score (apple or restart, even if value unchanged by saturation) SHALL set an internal pending flag.
REQ-017 Converter FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-018 IDLE: if pending=1 go to LOAD; else stay.
REQ-019 LOAD (1 cycle): capture score into 16-bit shift source, clear 20-bit BCD accumulator and 4-bit iteration counter, clear pending unless a new score write occurs on that same edge (write wins, pending stays 1); go to SHIFT.
REQ-020 SHIFT (exactly 16 cycles): each cycle add 3 to every BCD nibble >= 5, then shift {bcd, source} left by one (double-dabble); after 16th shift go to DONE.
REQ-021 DONE (1 cycle): digits <= BCD accumulator, digits_valid=1 for this cycle only; go to IDLE.
REQ-022 Latency: score written at edge N with converter idle -> digits reflect that score and digits_valid asserted after edge N+19 (IDLE 1 + LOAD 1 + SHIFT 16 + DONE 1).
REQ-023 A score write during LOAD/SHIFT/DONE SHALL NOT disturb the running conversion; pending causes exactly one further conversion using the latest score.
REQ-024 Multiple score writes while busy SHALL coalesce into a single follow-up conversion.
REQ-025 digits SHALL only change in DONE; no intermediate or partially converted value is ever visible.
REQ-026 busy SHALL be 1 in LOAD and SHIFT, 0 in IDLE and DONE.
REQ-027 Each digits nibble SHALL be 0..9; max score 65535 yields digits 6,5,5,3,5.

Reset
REQ-028 rst_n=0 at an edge SHALL force: score=0, high_score=0, digits=20'h00000, digits_valid=0, busy=0, pending=0, FSM=IDLE, counter=0.
REQ-029 Reset mid-conversion SHALL abort it; no digits_valid pulse follows until a new score write.
REQ-030 rst_n SHALL have priority over apple_eaten and game_restart on the same edge.

Verification
REQ-031 Reset, then one apple_eaten pulse -> score=1 next edge, digits=20'h00001 with digits_valid pulse 19 edges after score write, high_score=1.
REQ-032 Preload to 12345 via pulses, wait idle -> digits=20'h12345; then game_restart -> score=0, high_score=12345, digits=20'h00000 after 19 edges.
REQ-033 Drive 65540 apple pulses -> score saturates at 65535, digits=20'h65535, no wrap to 0.
REQ-034 Three apple pulses 2 cycles apart starting at score 7, first one with converter idle -> exactly two digits_valid pulses: first shows 20'h00008, second 20'h00010.
REQ-035 apple_eaten and game_restart together at score 40 -> score=0, high_score unchanged 40.
REQ-036 rst_n low during SHIFT of conversion for 999 -> all outputs zero next edge, no digits_valid afterwards while inputs idle.
